// File: rtl/crgu_dom_seq_if.sv
// Request/status bundle between the CRGU control plane and the domain sequencer.
// The sequencer takes the slave side. The master side (control plane or bench) drives the requests and delay fields.
interface crgu_dom_seq_if #(
    parameter int NCH = 8,
    parameter int DW  = 4
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] ch_en_i;
    logic [NCH-1:0] soft_rst_i;
    logic [DW-1:0]  rg_on_dly;
    logic [DW-1:0]  rg_off_dly;
    logic [NCH-1:0] clk_en_o;
    logic [NCH-1:0] rstn_o;
    logic [NCH-1:0] ch_ready_o;
    logic           busy_o;
    logic [CW-1:0]  active_ch_o;

    modport master (
        output ch_en_i, soft_rst_i, rg_on_dly, rg_off_dly,
        input  clk_en_o, rstn_o, ch_ready_o, busy_o, active_ch_o
    );

    modport slave (
        input  ch_en_i, soft_rst_i, rg_on_dly, rg_off_dly,
        output clk_en_o, rstn_o, ch_ready_o, busy_o, active_ch_o
    );
endinterface

// File: rtl/crgu_dom_seq.sv
// Power-domain sequencer: brings NCH clock/reset domains up, down or through soft reset
// one at a time. On turn-on the clock starts before reset is released. On turn-off reset is asserted before the clock stops.
module crgu_dom_seq #(
    parameter int NCH = 8,
    parameter int DW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scan_mode,
    crgu_dom_seq_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ON_WAIT   = 2'd1,
        OFF_WAIT  = 2'd2,
        SRST_WAIT = 2'd3
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [DW-1:0]  cnt_r, cnt_nxt_s;
    logic [CW-1:0]  idx_r, idx_nxt_s, sel_s;
    logic [NCH-1:0] clk_en_r, clk_en_nxt_s;
    logic [NCH-1:0] rstn_r, rstn_nxt_s;
    logic [NCH-1:0] ready_r, ready_nxt_s;
    logic [NCH-1:0] pend_r, pend_nxt_s;
    logic [NCH-1:0] need_s;
    logic           busy_r, busy_nxt_s;
    logic           any_s, sel_on_s, sel_off_s, cnt_zero_s;

    // Service requests and lowest-index-first selection
    always_comb begin
        need_s     = (bus.ch_en_i ^ ready_r) | (pend_r & ready_r & bus.ch_en_i);
        any_s      = |need_s;
        sel_s      = {CW{1'b0}};
        for (int k = NCH - 1; k >= 0; k--) begin
            sel_s = need_s[k] ? CW'(k) : sel_s;
        end
        sel_on_s   = bus.ch_en_i[sel_s] & ~ready_r[sel_s];
        sel_off_s  = ~bus.ch_en_i[sel_s] & ready_r[sel_s];
        cnt_zero_s = (cnt_r == {DW{1'b0}});
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {DW{1'b0}};
            idx_r    <= {CW{1'b0}};
            clk_en_r <= {NCH{1'b0}};
            rstn_r   <= {NCH{1'b0}};
            ready_r  <= {NCH{1'b0}};
            pend_r   <= {NCH{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            idx_r    <= idx_nxt_s;
            clk_en_r <= clk_en_nxt_s;
            rstn_r   <= rstn_nxt_s;
            ready_r  <= ready_nxt_s;
            pend_r   <= pend_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!any_s) begin
                    state_nxt_s = IDLE;
                end else if (sel_on_s) begin
                    state_nxt_s = ON_WAIT;
                end else if (sel_off_s) begin
                    state_nxt_s = OFF_WAIT;
                end else begin
                    state_nxt_s = SRST_WAIT;
                end
            end
            ON_WAIT, OFF_WAIT, SRST_WAIT: begin
                if (cnt_zero_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-domain outputs, gap counter and soft-reset bookkeeping
    always_comb begin
        cnt_nxt_s    = cnt_r;
        idx_nxt_s    = idx_r;
        busy_nxt_s   = busy_r;
        clk_en_nxt_s = clk_en_r;
        rstn_nxt_s   = rstn_r;
        ready_nxt_s  = ready_r;
        pend_nxt_s   = pend_r | bus.soft_rst_i;
        case (state_r)
            IDLE: begin
                // soft resets aimed at domains that are not up are dropped
                pend_nxt_s = pend_nxt_s & ready_r;
                if (any_s) begin
                    idx_nxt_s  = sel_s;
                    busy_nxt_s = 1'b1;
                    if (sel_on_s) begin
                        clk_en_nxt_s[sel_s] = 1'b1;
                        cnt_nxt_s           = bus.rg_on_dly;
                    end else begin
                        rstn_nxt_s[sel_s]  = 1'b0;
                        ready_nxt_s[sel_s] = 1'b0;
                        cnt_nxt_s          = bus.rg_off_dly;
                    end
                end else begin
                    idx_nxt_s  = {CW{1'b0}};
                    busy_nxt_s = 1'b0;
                end
            end
            ON_WAIT: begin
                if (cnt_zero_s) begin
                    rstn_nxt_s[idx_r]  = 1'b1;
                    ready_nxt_s[idx_r] = 1'b1;
                    idx_nxt_s          = {CW{1'b0}};
                    busy_nxt_s         = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - DW'(1'b1);
                end
            end
            OFF_WAIT: begin
                if (cnt_zero_s) begin
                    clk_en_nxt_s[idx_r] = 1'b0;
                    idx_nxt_s           = {CW{1'b0}};
                    busy_nxt_s          = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - DW'(1'b1);
                end
            end
            SRST_WAIT: begin
                if (cnt_zero_s) begin
                    rstn_nxt_s[idx_r]  = 1'b1;
                    ready_nxt_s[idx_r] = 1'b1;
                    pend_nxt_s[idx_r]  = 1'b0;
                    idx_nxt_s          = {CW{1'b0}};
                    busy_nxt_s         = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - DW'(1'b1);
                end
            end
            default: begin
                idx_nxt_s  = {CW{1'b0}};
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // In scan all clocks run and domain resets follow the global reset directly
    assign bus.clk_en_o    = scan_mode ? {NCH{1'b1}} : clk_en_r;
    assign bus.rstn_o      = scan_mode ? {NCH{rst_n}} : rstn_r;
    assign bus.ch_ready_o  = ready_r;
    assign bus.busy_o      = busy_r;
    assign bus.active_ch_o = idx_r;
endmodule

// File: tb/tb_crgu_dom_seq.sv
// Scoreboard bench for crgu_dom_seq: each stimulus step queues the output snapshots it should cause.
// A monitor compares them whenever any output changes.
module tb_crgu_dom_seq;
    typedef struct packed {
        int         c;
        logic [7:0] ce;
        logic [7:0] rn;
        logic [7:0] rd;
        logic       b;
        logic [2:0] a;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic scan_mode;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic fin = 1'b0;
    logic mon_done = 1'b0;
    ev_t  q[$];

    logic [7:0] ec, er, ey;
    logic       eb;
    logic [2:0] ea;

    crgu_dom_seq_if #(.NCH(8), .DW(4)) bus ();

    crgu_dom_seq #(.NCH(8), .DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_mode (scan_mode),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c);
        ev_t e;
        e.c  = c;
        e.ce = ec;
        e.rn = er;
        e.rd = ey;
        e.b  = eb;
        e.a  = ea;
        q.push_back(e);
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
    endtask

    task automatic check_now();
        ev_t got, want;
        got.c  = cyc;
        got.ce = bus.clk_en_o;
        got.rn = bus.rstn_o;
        got.rd = bus.ch_ready_o;
        got.b  = bus.busy_o;
        got.a  = bus.active_ch_o;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change got c=%0d clk_en=%h rstn=%h ready=%h busy=%b act=%0d want no change",
                     got.c, got.ce, got.rn, got.rd, got.b, got.a);
        end else begin
            want = q.pop_front();
            if (got !== want) begin
                bad++;
                $display("FAIL event got c=%0d clk_en=%h rstn=%h ready=%h busy=%b act=%0d want c=%0d clk_en=%h rstn=%h ready=%h busy=%b act=%0d",
                         got.c, got.ce, got.rn, got.rd, got.b, got.a,
                         want.c, want.ce, want.rn, want.rd, want.b, want.a);
            end
        end
        if (!scan_mode) begin
            total++;
            if ((bus.rstn_o & ~bus.clk_en_o) !== 8'h00) begin
                bad++;
                $display("FAIL rst_without_clk got rstn=%h clk_en=%h want rstn subset of clk_en",
                         bus.rstn_o, bus.clk_en_o);
            end
        end
    endtask

    initial begin : monitor
        #2;
        check_now();
        while (!fin) begin
            @(bus.clk_en_o or bus.rstn_o or bus.ch_ready_o or bus.busy_o or bus.active_ch_o or fin);
            if (!fin) begin
                #1;
                check_now();
            end
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_events got pending=%0d want 0 (next c=%0d)", q.size(), q[0].c);
        end
        mon_done = 1'b1;
    end

    initial begin : stim
        int n;
        int offl[5];
        offl = '{0, 2, 3, 4, 5};
        rst_n              = 1'b1;
        scan_mode          = 1'b0;
        bus.ch_en_i        = 8'hFF;
        bus.soft_rst_i     = 8'h00;
        bus.rg_on_dly      = 4'd1;
        bus.rg_off_dly     = 4'd2;
        ec = 8'h00; er = 8'h00; ey = 8'h00; eb = 1'b0; ea = 3'd0;
        push(0);
        #1 rst_n = 1'b0;

        // release: all eight domains come up in index order, 3 cycles apart
        tick(3);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n = cyc + 1 + 3 * k;
            ec[k] = 1'b1; eb = 1'b1; ea = 3'(k); push(n);
            er[k] = 1'b1; ey[k] = 1'b1; eb = 1'b0; ea = 3'd0; push(n + 2);
        end
        drain(); tick(2);

        // turn off domains 0,2,3,4,5 with rg_off_dly=5
        bus.rg_off_dly = 4'd5;
        bus.ch_en_i    = 8'hC2;
        n = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            er[offl[i]] = 1'b0; ey[offl[i]] = 1'b0; eb = 1'b1; ea = 3'(offl[i]); push(n);
            ec[offl[i]] = 1'b0; eb = 1'b0; ea = 3'd0; push(n + 6);
            n = n + 7;
        end
        drain(); tick(2);

        // turn on domain 2 with rg_on_dly=3; a mid-sequence delay change must not matter
        bus.rg_on_dly = 4'd3;
        bus.ch_en_i   = 8'hC6;
        n = cyc + 1;
        ec[2] = 1'b1; eb = 1'b1; ea = 3'd2; push(n);
        er[2] = 1'b1; ey[2] = 1'b1; eb = 1'b0; ea = 3'd0; push(n + 4);
        tick(2);
        bus.rg_on_dly = 4'd15;
        drain(); tick(2);

        // domains 0 and 5 requested together, rg_on_dly=1
        bus.rg_on_dly = 4'd1;
        bus.ch_en_i   = 8'hE7;
        n = cyc + 1;
        ec[0] = 1'b1; eb = 1'b1; ea = 3'd0; push(n);
        er[0] = 1'b1; ey[0] = 1'b1; eb = 1'b0; push(n + 2);
        ec[5] = 1'b1; eb = 1'b1; ea = 3'd5; push(n + 3);
        er[5] = 1'b1; ey[5] = 1'b1; eb = 1'b0; ea = 3'd0; push(n + 5);
        drain(); tick(2);

        // soft reset of domain 1, rg_off_dly=2, with a second pulse merged mid-sequence
        bus.rg_off_dly = 4'd2;
        bus.soft_rst_i = 8'h02;
        n = cyc + 2;
        er[1] = 1'b0; ey[1] = 1'b0; eb = 1'b1; ea = 3'd1; push(n);
        er[1] = 1'b1; ey[1] = 1'b1; eb = 1'b0; ea = 3'd0; push(n + 3);
        tick(1); bus.soft_rst_i = 8'h00;
        tick(1); bus.soft_rst_i = 8'h02;
        tick(1); bus.soft_rst_i = 8'h00;
        drain(); tick(2);
        // soft reset of disabled domain 4 causes nothing
        bus.soft_rst_i = 8'h10;
        tick(1); bus.soft_rst_i = 8'h00;
        tick(4);

        // abort a rg_on_dly=7 turn-on of domain 3 by reset, then scan bypass
        bus.rg_on_dly = 4'd7;
        bus.ch_en_i   = 8'hEF;
        n = cyc + 1;
        ec[3] = 1'b1; eb = 1'b1; ea = 3'd3; push(n);
        tick(3);
        ec = 8'h00; er = 8'h00; ey = 8'h00; eb = 1'b0; ea = 3'd0; push(cyc);
        rst_n = 1'b0;
        tick(1);
        ec = 8'hFF; push(cyc);
        scan_mode = 1'b1;
        tick(1);
        er = 8'hFF; push(cyc);
        rst_n = 1'b1;
        #3;
        er = 8'h00; push(cyc);
        rst_n = 1'b0;
        tick(1);
        ec = 8'h00; push(cyc);
        scan_mode = 1'b0;
        tick(1);
        bus.ch_en_i = 8'h00;
        rst_n = 1'b1;
        tick(4);

        drain(); tick(2);
        fin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mon_done) break;
            @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
